mmm_sequencer: RTL and testbench

- Sits in the MEM stage, directly downstream of the ID-stage decode of the MMM start and MMM wait instructions. It consumes the start_mmm / wait_mmm_finish flags and the rs2 configuration word carried down the pipeline registers.
- Runs an N x N integer matrix multiply, C = A x B. A, B and C live in a dual-read/single-write scratch memory at fixed base addresses.
- Tells the hazard logic to stall while a wait instruction is in MEM and a multiply is still running.

---
 rtl/mmm_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mmm_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmm_sequencer.sv
// MEM-stage sequencer for an N x N integer matrix multiply C = A x B over a
// dual-read/single-write scratch memory, with a stall request for MMM wait.
module mmm_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int MAX_N  = 16,
  parameter int A_BASE = 0,
  parameter int B_BASE = 256,
  parameter int C_BASE = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_mmm,
  input  logic              wait_mmm_finish,
  input  logic [DATA_W-1:0] cfg,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr_a,
  output logic [ADDR_W-1:0] mem_rd_addr_b,
  input  logic [DATA_W-1:0] mem_rd_data_a,
  input  logic [DATA_W-1:0] mem_rd_data_b,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              mmm_stall,
  output logic              start_err
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_e;

  localparam logic [ADDR_W-1:0] ABase = ADDR_W'(A_BASE);
  localparam logic [ADDR_W-1:0] BBase = ADDR_W'(B_BASE);
  localparam logic [ADDR_W-1:0] CBase = ADDR_W'(C_BASE);
  localparam logic [4:0]        MaxN  = 5'(MAX_N);

  state_e            state_q, state_d;
  logic [4:0]        dim_q, dim_d;
  logic [4:0]        row_q, row_d;
  logic [4:0]        col_q, col_d;
  logic [4:0]        kIdx_q, kIdx_d;
  logic [ADDR_W-1:0] rowOff_q, rowOff_d;
  logic [ADDR_W-1:0] kOff_q, kOff_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              startErr_q, startErr_d;

  logic [4:0]        cfgN;
  logic [4:0]        dimLast;
  logic [ADDR_W-1:0] dimExt;
  logic [DATA_W-1:0] product;
  logic              unusedCfg;

  assign cfgN      = cfg[4:0];
  assign unusedCfg = ^cfg[DATA_W-1:5];
  assign dimLast   = dim_q - 5'd1;
  assign dimExt    = ADDR_W'(dim_q);
  // The low DATA_W bits of a signed product equal those of the unsigned one.
  assign product   = mem_rd_data_a * mem_rd_data_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dim_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      kIdx_q     <= '0;
      rowOff_q   <= '0;
      kOff_q     <= '0;
      acc_q      <= '0;
      startErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dim_q      <= dim_d;
      row_q      <= row_d;
      col_q      <= col_d;
      kIdx_q     <= kIdx_d;
      rowOff_q   <= rowOff_d;
      kOff_q     <= kOff_d;
      acc_q      <= acc_d;
      startErr_q <= startErr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    dim_d         = dim_q;
    row_d         = row_q;
    col_d         = col_q;
    kIdx_d        = kIdx_q;
    rowOff_d      = rowOff_q;
    kOff_d        = kOff_q;
    acc_d         = acc_q;
    startErr_d    = startErr_q;
    mem_rd_en     = 1'b0;
    mem_rd_addr_a = '0;
    mem_rd_addr_b = '0;
    mem_wr_en     = 1'b0;
    mem_wr_addr   = '0;
    mem_wr_data   = '0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_mmm) begin
          if (cfgN == 5'd0) begin
            startErr_d = 1'b0;
            state_d    = DONE;
          end else if (cfgN > MaxN) begin
            startErr_d = 1'b1;
          end else begin
            dim_d      = cfgN;
            row_d      = '0;
            col_d      = '0;
            kIdx_d     = '0;
            rowOff_d   = '0;
            kOff_d     = '0;
            acc_d      = '0;
            startErr_d = 1'b0;
            state_d    = RUN;
          end
        end
      end

      // Data arriving now belongs to k-1, so the first k of an element adds nothing.
      RUN: begin
        busy          = 1'b1;
        mem_rd_en     = 1'b1;
        mem_rd_addr_a = ABase + rowOff_q + ADDR_W'(kIdx_q);
        mem_rd_addr_b = BBase + kOff_q + ADDR_W'(col_q);
        if (kIdx_q != 5'd0) acc_d = acc_q + product;
        if (kIdx_q == dimLast) begin
          state_d = DRAIN;
        end else begin
          kIdx_d = kIdx_q + 5'd1;
          kOff_d = kOff_q + dimExt;
        end
      end

      DRAIN: begin
        busy    = 1'b1;
        acc_d   = acc_q + product;
        state_d = WRITE;
      end

      WRITE: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_wr_addr = CBase + rowOff_q + ADDR_W'(col_q);
        mem_wr_data = acc_q;
        acc_d       = '0;
        kIdx_d      = '0;
        kOff_d      = '0;
        if (col_q != dimLast) begin
          col_d   = col_q + 5'd1;
          state_d = RUN;
        end else if (row_q != dimLast) begin
          col_d    = '0;
          row_d    = row_q + 5'd1;
          rowOff_d = rowOff_q + dimExt;
          state_d  = RUN;
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (start_mmm && busy) startErr_d = 1'b1;
  end

  assign mmm_stall = wait_mmm_finish & busy;
  assign start_err = startErr_q;

endmodule

// File: tb/tb_mmm_sequencer.sv
// Directed self-checking bench for mmm_sequencer with a registered-read
// scratch memory model and hand-computed expected results.
module tb_mmm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_mmm;
  logic        wait_mmm_finish;
  logic [31:0] cfg;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr_a;
  logic [9:0]  mem_rd_addr_b;
  logic [31:0] mem_rd_data_a;
  logic [31:0] mem_rd_data_b;
  logic        mem_wr_en;
  logic [9:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        busy;
  logic        done;
  logic        mmm_stall;
  logic        start_err;

  mmm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_mmm(start_mmm),
    .wait_mmm_finish(wait_mmm_finish), .cfg(cfg),
    .mem_rd_en(mem_rd_en), .mem_rd_addr_a(mem_rd_addr_a),
    .mem_rd_addr_b(mem_rd_addr_b), .mem_rd_data_a(mem_rd_data_a),
    .mem_rd_data_b(mem_rd_data_b), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .mmm_stall(mmm_stall), .start_err(start_err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data_a <= mem[mem_rd_addr_a];
      mem_rd_data_b <= mem[mem_rd_addr_b];
    end
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  int checkCount = 0;
  int passCount  = 0;

  int busyCycles, busyFirst, busyLast, doneCount, doneCycle;
  int rdCount, wrCount, stallCycles, stallIdle, errAtDone, stallAtDone, errAtEnd;
  logic [9:0]  wrAddrLog [16];
  logic [31:0] wrDataLog [16];
  int          wrCycleLog [16];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Issues one start with cfgVal at edge 0 and observes cycles 1..budget,
  // stopping two cycles after the first done pulse.
  task automatic applyStimulus(input logic [31:0] cfgVal, input int budget,
                               input int waitFrom, input int errStartAt);
    busyCycles = 0; busyFirst = -1; busyLast = -1; doneCount = 0; doneCycle = -1;
    rdCount = 0; wrCount = 0; stallCycles = 0; stallIdle = 0;
    errAtDone = -1; stallAtDone = -1; errAtEnd = -1;
    @(negedge clk);
    cfg = cfgVal;
    start_mmm = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (busy) begin
        busyCycles++;
        if (busyFirst < 0) busyFirst = c;
        busyLast = c;
      end
      if (done) begin
        doneCount++;
        if (doneCycle < 0) begin
          doneCycle   = c;
          errAtDone   = int'(start_err);
          stallAtDone = int'(mmm_stall);
        end
      end
      if (mem_rd_en) rdCount++;
      if (mem_wr_en) begin
        if (wrCount < 16) begin
          wrAddrLog[wrCount]  = mem_wr_addr;
          wrDataLog[wrCount]  = mem_wr_data;
          wrCycleLog[wrCount] = c;
        end
        wrCount++;
      end
      if (mmm_stall) begin
        stallCycles++;
        if (!busy) stallIdle++;
      end
      errAtEnd  = int'(start_err);
      start_mmm = (c == errStartAt);
      if (c == errStartAt) cfg = 32'd3;
      if (waitFrom > 0 && c + 1 == waitFrom) wait_mmm_finish = 1'b1;
      if (doneCycle > 0 && c >= doneCycle + 2) break;
    end
    start_mmm       = 1'b0;
    wait_mmm_finish = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags"},
                {26'd0, busy, done, mmm_stall, start_err, mem_rd_en, mem_wr_en}, 32'd0);
    checkOutput({tag, "_addr"},
                {22'd0, mem_rd_addr_a | mem_rd_addr_b | mem_wr_addr}, 32'd0);
    checkOutput({tag, "_wdata"}, mem_wr_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_mmm = 1'b0;
    wait_mmm_finish = 1'b0;
    cfg = 32'd0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'd0;

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // N=1: 3 * -5
    mem[0] = 32'd3; mem[256] = 32'hFFFF_FFFB;
    applyStimulus(32'd1, 20, 0, 0);
    checkOutput("n1_busy_first", busyFirst, 1);
    checkOutput("n1_busy_last", busyLast, 3);
    checkOutput("n1_busy_cycles", busyCycles, 3);
    checkOutput("n1_rd_count", rdCount, 1);
    checkOutput("n1_wr_count", wrCount, 1);
    checkOutput("n1_wr_addr", {22'd0, wrAddrLog[0]}, 32'd512);
    checkOutput("n1_wr_data", wrDataLog[0], 32'hFFFF_FFF1);
    checkOutput("n1_wr_cycle", wrCycleLog[0], 3);
    checkOutput("n1_done_cycle", doneCycle, 4);
    checkOutput("n1_done_count", doneCount, 1);

    // N=2: A=[[1,2],[3,4]], B=identity
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
    mem[256] = 32'd1; mem[257] = 32'd0; mem[258] = 32'd0; mem[259] = 32'd1;
    applyStimulus(32'd2, 40, 0, 0);
    checkOutput("id_busy_cycles", busyCycles, 16);
    checkOutput("id_rd_count", rdCount, 8);
    checkOutput("id_wr_count", wrCount, 4);
    for (int w = 0; w < 4; w++) begin
      checkOutput($sformatf("id_wr_addr%0d", w), {22'd0, wrAddrLog[w]}, 32'(512 + w));
      checkOutput($sformatf("id_wr_data%0d", w), wrDataLog[w], 32'(w + 1));
    end
    checkOutput("id_done_cycle", doneCycle, 17);
    checkOutput("id_done_count", doneCount, 1);

    // N=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]]
    mem[256] = 32'd5; mem[257] = 32'd6; mem[258] = 32'd7; mem[259] = 32'd8;
    applyStimulus(32'd2, 40, 0, 0);
    checkOutput("mul_wr_count", wrCount, 4);
    checkOutput("mul_c00", wrDataLog[0], 32'd19);
    checkOutput("mul_c01", wrDataLog[1], 32'd22);
    checkOutput("mul_c10", wrDataLog[2], 32'd43);
    checkOutput("mul_c11", wrDataLog[3], 32'd50);
    checkOutput("mul_c11_addr", {22'd0, wrAddrLog[3]}, 32'd515);

    // Wait held high from cycle 2 of an N=2 run
    mem[256] = 32'd1; mem[257] = 32'd0; mem[258] = 32'd0; mem[259] = 32'd1;
    applyStimulus(32'd2, 40, 2, 0);
    checkOutput("stall_cycles", stallCycles, 15);
    checkOutput("stall_when_idle", stallIdle, 0);
    checkOutput("stall_at_done", stallAtDone, 0);
    checkOutput("stall_done_count", doneCount, 1);

    // Start with N=3 issued mid-run is rejected
    applyStimulus(32'd2, 40, 0, 5);
    checkOutput("err_busy_cycles", busyCycles, 16);
    checkOutput("err_wr_count", wrCount, 4);
    for (int w = 0; w < 4; w++)
      checkOutput($sformatf("err_wr_data%0d", w), wrDataLog[w], 32'(w + 1));
    checkOutput("err_flag_at_done", errAtDone, 1);

    // N=0 completes immediately and clears the error flag
    applyStimulus(32'd0, 10, 0, 0);
    checkOutput("n0_done_cycle", doneCycle, 1);
    checkOutput("n0_busy_cycles", busyCycles, 0);
    checkOutput("n0_rdwr_count", rdCount + wrCount, 0);
    checkOutput("n0_err_cleared", errAtEnd, 0);

    // N=17 is rejected
    applyStimulus(32'd17, 6, 0, 0);
    checkOutput("n17_done_count", doneCount, 0);
    checkOutput("n17_busy_cycles", busyCycles, 0);
    checkOutput("n17_rdwr_count", rdCount + wrCount, 0);
    checkOutput("n17_err_set", errAtEnd, 1);

    // N=1 wraparound; accepted start clears error
    mem[0] = 32'h7FFF_FFFF; mem[256] = 32'd2;
    applyStimulus(32'd1, 20, 0, 0);
    checkOutput("wrap_wr_data", wrDataLog[0], 32'hFFFF_FFFE);
    checkOutput("wrap_done_count", doneCount, 1);
    checkOutput("wrap_err_cleared", errAtEnd, 0);

    // N=4: A[i][k]=4i+k, B=2*I, so C[i][j]=2*(4i+j)
    for (int e = 0; e < 16; e++) begin
      mem[e]       = 32'(e);
      mem[256 + e] = (e % 5 == 0) ? 32'd2 : 32'd0;
    end
    applyStimulus(32'd4, 10, 0, 0);
    checkOutput("rst_run_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("midrst");
    wrCount = 0;
    busyCycles = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (mem_wr_en) wrCount++;
      if (busy) busyCycles++;
    end
    checkOutput("midrst_no_writes", wrCount, 0);
    checkOutput("midrst_stays_idle", busyCycles, 0);

    applyStimulus(32'd4, 150, 0, 0);
    checkOutput("n4_busy_cycles", busyCycles, 96);
    checkOutput("n4_wr_count", wrCount, 16);
    checkOutput("n4_done_count", doneCount, 1);
    for (int w = 0; w < 16; w++) begin
      checkOutput($sformatf("n4_wr_addr%0d", w), {22'd0, wrAddrLog[w]}, 32'(512 + w));
      checkOutput($sformatf("n4_wr_data%0d", w), wrDataLog[w], 32'(2 * w));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
